// File: rtl/div_issue.sv
// div_issue: EX-stage controller for the iterative divider.
// It captures the DIV/DIVU operands, holds the divider start line high and
// stalls the pipeline until the divider reports ready. The result is then
// presented as HI/LO write data. Flush annuls the divide, and a watchdog
// aborts a divide whose ready never arrives.
module div_issue #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_req_i,
   input  logic        div_signed_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        div_signed_o,
   output logic [31:0] div_opdata1_o,
   output logic [31:0] div_opdata2_o,
   output logic        stallreq_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        err_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_inc;
   logic          timeout;

   logic          start_reg;
   logic          signed_reg;
   logic [31:0]   op1_reg, op2_reg;
   logic [31:0]   hi_reg, lo_reg;
   logic          err_reg;

   // Per-cycle control decoded from the FSM, consumed by the datapath block.
   logic          accept;
   logic          res_load;
   logic          to_load;
   logic          clr_start;

   // The counter reaches TIMEOUT in the TIMEOUT-th BUSY cycle, where the
   // counter is 0 in the first BUSY cycle.
   assign cnt_inc = cnt_reg + 1'b1;
   assign timeout = (cnt_inc == TIMEOUT_C);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // Next-state and combinational outputs. Flush wins over ready, and ready
   // wins over the watchdog.
   always_comb begin
      state_next  = state_reg;
      accept      = 1'b0;
      res_load    = 1'b0;
      to_load     = 1'b0;
      clr_start   = 1'b0;
      div_annul_o = 1'b0;
      stallreq_o  = 1'b0;
      whilo_o     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (div_req_i && !flush_i) begin
               accept     = 1'b1;
               stallreq_o = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            stallreq_o = 1'b1;
            if (flush_i) begin
               div_annul_o = 1'b1;
               clr_start   = 1'b1;
               state_next  = IDLE;
            end else if (div_ready_i) begin
               res_load   = 1'b1;
               clr_start  = 1'b1;
               state_next = DONE;
            end else if (timeout) begin
               div_annul_o = 1'b1;
               to_load     = 1'b1;
               clr_start   = 1'b1;
               state_next  = DONE;
            end
         end
         DONE: begin
            whilo_o = !flush_i;
            if (flush_i || !stall_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, start line, watchdog counter, result and error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_reg  <= 1'b0;
         signed_reg <= 1'b0;
         op1_reg    <= '0;
         op2_reg    <= '0;
         cnt_reg    <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         err_reg    <= 1'b0;
      end else begin
         if (accept) begin
            start_reg  <= 1'b1;
            signed_reg <= div_signed_i;
            op1_reg    <= reg1_i;
            op2_reg    <= reg2_i;
            cnt_reg    <= '0;
         end
         if (state_reg == BUSY) cnt_reg <= cnt_inc;
         if (clr_start) start_reg <= 1'b0;
         if (res_load) begin
            hi_reg <= div_result_i[63:32];
            lo_reg <= div_result_i[31:0];
         end
         if (to_load) begin
            hi_reg  <= '0;
            lo_reg  <= '0;
            err_reg <= 1'b1;
         end
      end
   end

   assign div_start_o   = start_reg;
   assign div_signed_o  = signed_reg;
   assign div_opdata1_o = op1_reg;
   assign div_opdata2_o = op2_reg;
   assign hi_o          = hi_reg;
   assign lo_o          = lo_reg;
   assign err_o         = err_reg;

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue. The divider is played by the scenario tasks,
// which raise ready on chosen cycles with hand-computed results.
module tb_div_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        div_req, div_signed, flush, stall, div_ready;
   logic [31:0] reg1, reg2;
   logic [63:0] div_result;
   logic        start, annul, signed_o, stallreq, whilo, err;
   logic [31:0] op1, op2, hi, lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_issue #(.TIMEOUT(40)) dut (
      .clk(clk), .rst(rst),
      .div_req_i(div_req), .div_signed_i(div_signed),
      .reg1_i(reg1), .reg2_i(reg2),
      .flush_i(flush), .stall_i(stall),
      .div_result_i(div_result), .div_ready_i(div_ready),
      .div_start_o(start), .div_annul_o(annul), .div_signed_o(signed_o),
      .div_opdata1_o(op1), .div_opdata2_o(op2),
      .stallreq_o(stallreq), .whilo_o(whilo),
      .hi_o(hi), .lo_o(lo), .err_o(err)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; div_req = 0; div_signed = 0; flush = 0; stall = 0;
      div_ready = 0; reg1 = 0; reg2 = 0; div_result = 0;
      #3;
      checks++; if ({start, annul, signed_o, stallreq, whilo, err} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 000000", {start, annul, signed_o, stallreq, whilo, err});
      end
      checks++; if ({op1, op2, hi, lo} !== 128'b0) begin
         errors++; $display("FAIL reset_data got %h exp 0", {op1, op2, hi, lo});
      end
      @(posedge clk); #1; rst = 1'b1;
      tick; #1;
      checks++; if (stallreq !== 1'b0 || start !== 1'b0) begin
         errors++; $display("FAIL idle_no_req got stallreq=%b start=%b exp 0 0", stallreq, start);
      end
   endtask

   task automatic test_divu;
      div_req = 1; div_signed = 0; reg1 = 32'd100; reg2 = 32'd7; #1;
      checks++; if (stallreq !== 1'b1 || start !== 1'b0) begin
         errors++; $display("FAIL divu_req_cycle got stallreq=%b start=%b exp 1 0", stallreq, start);
      end
      tick; #1;
      checks++; if (start !== 1'b1 || op1 !== 32'd100 || op2 !== 32'd7 || signed_o !== 1'b0) begin
         errors++; $display("FAIL divu_start got start=%b op1=%0d op2=%0d sgn=%b exp 1 100 7 0", start, op1, op2, signed_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick; #1;
         checks++; if (stallreq !== 1'b1 || annul !== 1'b0) begin
            errors++; $display("FAIL divu_busy_stall got stallreq=%b annul=%b exp 1 0", stallreq, annul);
         end
      end
      tick; div_ready = 1; div_result = {32'd2, 32'd14}; #1;
      checks++; if (stallreq !== 1'b1 || whilo !== 1'b0) begin
         errors++; $display("FAIL divu_ready_cycle got stallreq=%b whilo=%b exp 1 0", stallreq, whilo);
      end
      tick; div_ready = 0; div_req = 0; #1;
      checks++; if (hi !== 32'd2 || lo !== 32'd14 || whilo !== 1'b1 || stallreq !== 1'b0 || start !== 1'b0) begin
         errors++; $display("FAIL divu_done got hi=%0d lo=%0d whilo=%b stallreq=%b start=%b exp 2 14 1 0 0", hi, lo, whilo, stallreq, start);
      end
      tick; #1;
      checks++; if (whilo !== 1'b0) begin
         errors++; $display("FAIL divu_whilo_one_cycle got %b exp 0", whilo);
      end
   endtask

   task automatic test_signed;
      div_req = 1; div_signed = 1; reg1 = 32'hFFFF_FF9C; reg2 = 32'd7;
      tick; #1;
      checks++; if (signed_o !== 1'b1 || op1 !== 32'hFFFF_FF9C) begin
         errors++; $display("FAIL div_signed_latch got sgn=%b op1=%h exp 1 ffffff9c", signed_o, op1);
      end
      reg1 = 32'h1234_5678; reg2 = 32'h0000_0003; div_signed = 0;
      for (int i = 0; i < 3; i++) tick;
      #1;
      checks++; if (signed_o !== 1'b1 || op1 !== 32'hFFFF_FF9C || op2 !== 32'd7 || start !== 1'b1) begin
         errors++; $display("FAIL div_ops_held got sgn=%b op1=%h op2=%h start=%b exp 1 ffffff9c 00000007 1", signed_o, op1, op2, start);
      end
      tick; div_ready = 1; div_result = {32'hFFFF_FFFE, 32'hFFFF_FFF2};
      tick; div_ready = 0; div_req = 0; #1;
      checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2 || whilo !== 1'b1) begin
         errors++; $display("FAIL div_signed_result got hi=%h lo=%h whilo=%b exp fffffffe fffffff2 1", hi, lo, whilo);
      end
      tick;
   endtask

   task automatic test_flush;
      div_req = 1; div_signed = 0; reg1 = 32'd9; reg2 = 32'd3;
      tick;                                   // BUSY cycle 1
      for (int i = 2; i <= 9; i++) tick;      // BUSY cycle 9
      #1;
      checks++; if (annul !== 1'b0) begin
         errors++; $display("FAIL flush_no_annul_early got %b exp 0", annul);
      end
      tick; flush = 1; #1;                    // BUSY cycle 10
      checks++; if (annul !== 1'b1) begin
         errors++; $display("FAIL flush_annul got %b exp 1", annul);
      end
      tick; flush = 0; div_req = 0; #1;
      checks++; if (start !== 1'b0 || annul !== 1'b0 || stallreq !== 1'b0 || whilo !== 1'b0) begin
         errors++; $display("FAIL flush_idle got start=%b annul=%b stallreq=%b whilo=%b exp 0 0 0 0", start, annul, stallreq, whilo);
      end
      // Flush arriving together with ready must not write HI/LO.
      div_req = 1;
      tick; tick; tick;
      flush = 1; div_ready = 1; div_result = {32'd1, 32'd1}; #1;
      checks++; if (annul !== 1'b1) begin
         errors++; $display("FAIL flush_ready_annul got %b exp 1", annul);
      end
      tick; flush = 0; div_ready = 0; div_req = 0; #1;
      checks++; if (whilo !== 1'b0 || start !== 1'b0 || hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2) begin
         errors++; $display("FAIL flush_ready_nowrite got whilo=%b start=%b hi=%h lo=%h exp 0 0 fffffffe fffffff2", whilo, start, hi, lo);
      end
      tick;
   endtask

   task automatic test_back_to_back;
      div_req = 1; div_signed = 0; reg1 = 32'd50; reg2 = 32'd6;
      tick; tick;
      div_ready = 1; div_result = {32'd2, 32'd8}; stall = 1;
      tick; div_ready = 0;
      for (int i = 1; i <= 3; i++) begin
         if (i == 2) begin reg1 = 32'd77; reg2 = 32'd5; end
         #1;
         checks++; if (whilo !== 1'b1 || hi !== 32'd2 || lo !== 32'd8 || start !== 1'b0 || stallreq !== 1'b0) begin
            errors++; $display("FAIL stall_done_hold%0d got whilo=%b hi=%0d lo=%0d start=%b stallreq=%b exp 1 2 8 0 0", i, whilo, hi, lo, start, stallreq);
         end
         tick;
      end
      // Release cycle: the next DIV is already presented by EX.
      stall = 0; reg1 = 32'd77; reg2 = 32'd5;
      tick; #1;
      checks++; if (start !== 1'b0 || whilo !== 1'b0 || stallreq !== 1'b1) begin
         errors++; $display("FAIL b2b_idle got start=%b whilo=%b stallreq=%b exp 0 0 1", start, whilo, stallreq);
      end
      tick; #1;
      checks++; if (start !== 1'b1 || op1 !== 32'd77 || op2 !== 32'd5) begin
         errors++; $display("FAIL b2b_start got start=%b op1=%0d op2=%0d exp 1 77 5", start, op1, op2);
      end
      div_ready = 1; div_result = {32'd2, 32'd15};
      tick; div_ready = 0; div_req = 0; #1;
      checks++; if (hi !== 32'd2 || lo !== 32'd15 || whilo !== 1'b1) begin
         errors++; $display("FAIL b2b_result got hi=%0d lo=%0d whilo=%b exp 2 15 1", hi, lo, whilo);
      end
      tick;
   endtask

   task automatic test_timeout;
      div_req = 1; div_signed = 0; reg1 = 32'd1; reg2 = 32'd1;
      for (int k = 1; k <= 40; k++) begin
         tick; #1;
         if (k < 40) begin
            if (annul !== 1'b0) begin
               checks++; errors++; $display("FAIL timeout_early_annul cycle %0d got %b exp 0", k, annul);
            end
         end else begin
            checks++; if (annul !== 1'b1 || stallreq !== 1'b1) begin
               errors++; $display("FAIL timeout_annul got annul=%b stallreq=%b exp 1 1", annul, stallreq);
            end
         end
      end
      tick; div_req = 0; #1;
      checks++; if (err !== 1'b1 || hi !== 32'd0 || lo !== 32'd0 || whilo !== 1'b1 || stallreq !== 1'b0 || start !== 1'b0) begin
         errors++; $display("FAIL timeout_done got err=%b hi=%h lo=%h whilo=%b stallreq=%b start=%b exp 1 0 0 1 0 0", err, hi, lo, whilo, stallreq, start);
      end
      tick; #1;
      checks++; if (err !== 1'b1 || whilo !== 1'b0) begin
         errors++; $display("FAIL timeout_sticky got err=%b whilo=%b exp 1 0", err, whilo);
      end
   endtask

   task automatic test_async_reset;
      div_req = 1; div_signed = 1; reg1 = 32'd200; reg2 = 32'd9;
      tick; tick; tick; #1;
      rst = 1'b0; div_req = 0; #1;
      checks++; if ({start, annul, signed_o, stallreq, whilo, err} !== 6'b0 || {op1, op2, hi, lo} !== 128'b0) begin
         errors++; $display("FAIL async_reset got ctrl=%b data=%h exp 0 0", {start, annul, signed_o, stallreq, whilo, err}, {op1, op2, hi, lo});
      end
      #3; rst = 1'b1;
      tick;
      div_req = 1; div_signed = 0; reg1 = 32'd81; reg2 = 32'd9; #1;
      checks++; if (stallreq !== 1'b1 || start !== 1'b0) begin
         errors++; $display("FAIL post_reset_req got stallreq=%b start=%b exp 1 0", stallreq, start);
      end
      tick; #1;
      checks++; if (start !== 1'b1 || op1 !== 32'd81 || op2 !== 32'd9) begin
         errors++; $display("FAIL post_reset_start got start=%b op1=%0d op2=%0d exp 1 81 9", start, op1, op2);
      end
      div_ready = 1; div_result = {32'd0, 32'd9};
      tick; div_ready = 0; div_req = 0; #1;
      checks++; if (hi !== 32'd0 || lo !== 32'd9 || whilo !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL post_reset_result got hi=%0d lo=%0d whilo=%b err=%b exp 0 9 1 0", hi, lo, whilo, err);
      end
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL time_limit reached got running exp finished");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_divu;
      test_signed;
      test_flush;
      test_back_to_back;
      test_timeout;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
